// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched
// Brief    : Round-robin scheduler sharing one external counter among
//            NUM_REQ requesters, each timing an interval of req_len counts.
// Revision : 1.0
// ============================================================================
module counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     err,
    output logic                     count_en,
    output logic                     count_clr,
    input  logic [CNT_W-1:0]         count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_inc;
    logic [IW-1:0]    win;
    logic [CNT_W-1:0] win_len;
    logic [CNT_W-1:0] len_q;
    logic             win_vld;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win     = ptr;
        win_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win     = IW'(j);
                win_len = req_len[j*CNT_W +: CNT_W];
            end
        end
    end

    assign idx_inc  = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    // Combinational so enable drops in the same cycle count reaches len_q.
    assign count_en = (state == ST_RUN) && (count != len_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            idx       <= '0;
            len_q     <= '0;
            err       <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            count_clr <= 1'b0;
        end else begin
            done      <= '0;
            count_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        idx       <= win;
                        len_q     <= win_len;
                        state     <= ST_CLEAR;
                        gnt       <= onehot(win);
                        busy      <= 1'b1;
                        count_clr <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!req[idx]) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= idx_inc;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (count > len_q || !req[idx]) begin
                        // Overshoot means the counter is out of step with us.
                        if (count > len_q) begin
                            err <= 1'b1;
                        end
                        state <= ST_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= idx_inc;
                    end else if (count == len_q) begin
                        state <= ST_DONE;
                        done  <= onehot(idx);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= idx_inc;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one `counter` instance among NUM_REQ requesters, each needing a timed interval of a requested number of counts. It owns the counter's `count_en` and `count_clr` inputs and watches its `count` output. For each grant it clears the counter, enables it until `count` equals the requested length, then signals completion to the granted requester.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- CNT_W, 8: counter width, matches the `counter` instance
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- req  input  NUM_REQ  per-requester request level; hold high until `done` or abort
- req_len  input  NUM_REQ*CNT_W  packed target counts; requester i uses bits [i*CNT_W +: CNT_W]
- gnt  output  NUM_REQ  one-hot grant, all-zero when idle
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester
- busy  output  1  high whenever FSM is not IDLE
- err  output  1  sticky: counter out of step during RUN; cleared only by reset
- count_en  output  1  to `counter.count_en`
- count_clr  output  1  to `counter.count_clr`
- count  input  CNT_W  from `counter.count`

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. Registered state; outputs decoded from state and registered index/length.
- Round-robin pointer `p`, reset to 0. In IDLE, search req[p], req[p+1], … modulo NUM_REQ. The first set bit is the winner `idx`.
- IDLE: if any req is high, latch `idx` and `len_q = req_len[idx]`, then go to CLEAR. Later changes to req_len are ignored for this grant.
- CLEAR: count_clr=1, count_en=0; go to RUN next cycle.
- RUN: count_en = (count != len_q); count_clr=0.
  - count == len_q → DONE.
  - count > len_q → set err, go to IDLE with no done; p = idx+1.
- DONE: done[idx]=1 for this cycle only; go to IDLE; p = idx+1 mod NUM_REQ.
- Abort: req[idx] low in CLEAR or RUN → next state IDLE, no done pulse, p = idx+1. The counter is left as is; the next grant clears it.
- gnt[idx]=1 in CLEAR, RUN and DONE; 0 in IDLE. busy = (state != IDLE).
- The counter's overflow output is not used. len_q ≤ 2^CNT_W−1, so enable stops before any wrap.
- Width rule: comparisons are unsigned, CNT_W bits; p and idx are $clog2(NUM_REQ) bits.

## Timing
- Reset (rst_n low at an edge, in any state including mid-RUN): the next cycle has state=IDLE, p=0, err=0 and gnt, done, busy, count_en, count_clr all 0.
- req high when sampled in IDLE at edge k → gnt and count_clr high in cycle k+1 (CLEAR).
- The counter clears at the edge ending CLEAR. RUN then lasts len_q+1 cycles, with count_en high for the first len_q of them.
- Grant length = len_q+3 cycles (CLEAR + RUN + DONE). done coincides with the last grant cycle.
- At least one IDLE cycle separates consecutive grants. Back-to-back throughput is one grant per len_q+4 cycles.
- len_q = 0: RUN lasts 1 cycle with count_en never asserted; grant is 3 cycles.
- Simultaneous requests are resolved by the pointer only; a requester re-asserting right after its own done loses to any other pending requester.

## Test plan
- Reset: hold rst_n low 2 cycles with req=4'hF → gnt=0, done=0, busy=0, count_en=0, count_clr=0, err=0. After release, gnt=4'b0001 one cycle later.
- Single request: req[0]=1, len=5 → count_clr high 1 cycle, count_en high 5 cycles, count reaches 5 and holds, done[0] one pulse, gnt[0] high 8 cycles.
- Zero length: req[2]=1, len=0 → count_en never high, gnt[2] high 3 cycles, done[2] in the 3rd cycle.
- Fairness: req=4'hF held, all len=2 → grant order 0,1,2,3,0. Each grant lasts 5 cycles with 1 IDLE cycle between grants.
- Abort: req[1] dropped in the 2nd RUN cycle → gnt[1] low next cycle, no done[1], next pending requester granted after one IDLE cycle.
- Boundary and err:
  - len=8'hFF → count reaches 8'hFF, done asserted, no wrap to 8'h00.
  - Force count=8'h09 during a len=3 RUN → err=1 and stays 1 until rst_n low.
